// File: rtl/ofdm_frame_sequencer.sv
// OFDM frame sequencer: after a preamble trigger, drops an offset, then
// alternates CP gaps (dropped) and FFT frames (passed, tlast on last beat).
//
// Ports:
//   ce_clk, ce_rst_n               clock, async active-low reset
//   set_stb/set_addr/set_data      settings bus writes
//   i_tdata/i_ttrig/i_tvalid/i_tready  sample stream in (trig = preamble)
//   o_tdata/o_tlast/o_tvalid/o_tready  framed stream out (zero latency)
//   busy         high whenever not IDLE
//   frame_count  frames completed since last trigger (saturating)
//   cfg_err      sticky, trigger seen with frame_len == 0
module ofdm_frame_sequencer #(
    parameter int SR_BASE       = 16,
    parameter int LEN_W         = 16,
    parameter int DEF_FRAME_LEN = 64,
    parameter int DEF_GAP_LEN   = 16
) (
    input  logic        ce_clk,
    input  logic        ce_rst_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_ttrig,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        cfg_err
);

    typedef enum logic [1:0] {IDLE, OFFSET, GAP, FRAME} state_t;

    localparam logic [7:0] A_FRAME = 8'(SR_BASE + 0);
    localparam logic [7:0] A_GAP   = 8'(SR_BASE + 1);
    localparam logic [7:0] A_OFF   = 8'(SR_BASE + 2);
    localparam logic [7:0] A_MAX   = 8'(SR_BASE + 3);
    localparam logic [7:0] A_ABORT = 8'(SR_BASE + 4);
    localparam logic [7:0] A_CLR   = 8'(SR_BASE + 5);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t state, state_nxt;

    logic [LEN_W-1:0] frame_len, gap_len, offset, max_frames;
    logic [LEN_W-1:0] sh_frame, sh_gap, sh_off, sh_max;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic             abort_pend;

    logic        beat, trig, wr_abort, wr_clr;
    logic        frame_end, frame_done;
    logic [15:0] fc_inc;
    logic        unused_bits;

    assign unused_bits = ^set_data;

    assign beat     = i_tvalid & i_tready;
    assign trig     = (state == IDLE) & beat & i_ttrig;
    assign wr_abort = set_stb & (set_addr == A_ABORT);
    assign wr_clr   = set_stb & (set_addr == A_CLR);
    assign o_tdata  = i_tdata;
    assign busy     = (state != IDLE);

    assign frame_end  = (state == FRAME) & beat & (cnt == sh_frame - ONE);
    assign fc_inc     = (frame_count == 16'hFFFF) ? frame_count
                                                  : frame_count + 16'd1;
    assign frame_done = frame_end & (sh_max != '0)
                      & (32'(fc_inc) == 32'(sh_max));

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            frame_len  <= LEN_W'(DEF_FRAME_LEN);
            gap_len    <= LEN_W'(DEF_GAP_LEN);
            offset     <= '0;
            max_frames <= '0;
        end else if (set_stb) begin
            if (set_addr == A_FRAME) frame_len  <= set_data[LEN_W-1:0];
            if (set_addr == A_GAP)   gap_len    <= set_data[LEN_W-1:0];
            if (set_addr == A_OFF)   offset     <= set_data[LEN_W-1:0];
            if (set_addr == A_MAX)   max_frames <= set_data[LEN_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        i_tready  = 1'b1;
        o_tvalid  = 1'b0;
        o_tlast   = 1'b0;
        unique case (state)
            IDLE: begin
                if (trig && !wr_abort && frame_len != '0) begin
                    if (offset != '0)       state_nxt = OFFSET;
                    else if (gap_len != '0) state_nxt = GAP;
                    else                    state_nxt = FRAME;
                end
            end
            OFFSET: begin
                if (wr_abort)
                    state_nxt = IDLE;
                else if (beat && cnt == sh_off - ONE)
                    state_nxt = (sh_gap != '0) ? GAP : FRAME;
            end
            GAP: begin
                if (wr_abort)
                    state_nxt = IDLE;
                else if (beat && cnt == sh_gap - ONE)
                    state_nxt = FRAME;
            end
            FRAME: begin
                o_tvalid = i_tvalid;
                i_tready = o_tready;
                o_tlast  = (cnt == sh_frame - ONE);
                // An abort only takes effect at a frame boundary
                if (frame_end) begin
                    if (frame_done || abort_pend || wr_abort)
                        state_nxt = IDLE;
                    else if (sh_gap != '0)
                        state_nxt = GAP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Count restarts on every state change and on back-to-back frames
    always_comb begin
        if (state_nxt != state || frame_end)
            cnt_nxt = '0;
        else if (beat && state != IDLE)
            cnt_nxt = cnt + ONE;
        else
            cnt_nxt = cnt;
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            abort_pend  <= 1'b0;
            frame_count <= '0;
            cfg_err     <= 1'b0;
            sh_frame    <= LEN_W'(DEF_FRAME_LEN);
            sh_gap      <= LEN_W'(DEF_GAP_LEN);
            sh_off      <= '0;
            sh_max      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state_nxt == IDLE)
                abort_pend <= 1'b0;
            else if (wr_abort && state == FRAME)
                abort_pend <= 1'b1;
            if (trig) begin
                sh_frame    <= frame_len;
                sh_gap      <= gap_len;
                sh_off      <= offset;
                sh_max      <= max_frames;
                frame_count <= '0;
            end else if (frame_end) begin
                frame_count <= fc_inc;
            end
            if (trig && frame_len == '0)
                cfg_err <= 1'b1;
            else if (wr_clr)
                cfg_err <= 1'b0;
        end
    end

endmodule
